// File: rtl/m_axi_rd_dma.sv
// m_axi_rd_dma: AXI4 read-master DMA that fetches a contiguous byte range and
// forwards the read data unchanged onto an AXI4-Stream output.
//
// Ports
//   I_aclk, I_arst            clock, synchronous active-high reset
//   I_start, O_start_done     level start request / one-cycle acceptance pulse
//   I_ddr_rd_addr             base byte address (aligned down to the bus width)
//   I_in_data_bytes           transfer length in bytes (rounded up to whole beats)
//   O_ap_done, O_ap_ready     completion pulse / idle indication
//   O_m_ar*, I_m_arready      AXI4 read address channel (INCR, one burst in flight)
//   I_m_r*, O_m_rready        AXI4 read data channel
//   O_axis_t*, I_axis_tready  output stream (combinational pass-through of R)
//   O_err                     sticky read-response error flag
//
// Build option: define RD_RESP_CHK_EN to flag non-OKAY read responses on
// O_err; without it rresp is ignored and O_err is held at 0.
module m_axi_rd_dma #(
    parameter int unsigned C_ADDR_WIDTH = 32,
    parameter int unsigned C_DATA_WIDTH = 64,
    parameter int unsigned C_MAX_BURST  = 16
) (
    input  logic                    I_aclk,
    input  logic                    I_arst,
    input  logic                    I_start,
    input  logic [31:0]             I_ddr_rd_addr,
    input  logic [31:0]             I_in_data_bytes,
    output logic                    O_start_done,
    output logic                    O_ap_done,
    output logic                    O_ap_ready,
    output logic [C_ADDR_WIDTH-1:0] O_m_araddr,
    output logic [7:0]              O_m_arlen,
    output logic [2:0]              O_m_arsize,
    output logic [1:0]              O_m_arburst,
    output logic                    O_m_arvalid,
    input  logic                    I_m_arready,
    input  logic [C_DATA_WIDTH-1:0] I_m_rdata,
    input  logic [1:0]              I_m_rresp,
    input  logic                    I_m_rlast,
    input  logic                    I_m_rvalid,
    output logic                    O_m_rready,
    output logic [C_DATA_WIDTH-1:0] O_axis_tdata,
    output logic                    O_axis_tvalid,
    output logic                    O_axis_tlast,
    input  logic                    I_axis_tready,
    output logic                    O_err
);

    localparam int unsigned BPB    = C_DATA_WIDTH / 8;
    localparam int unsigned LG_BPB = $clog2(BPB);

    typedef enum logic [1:0] {
        IDLE,
        AR,
        RD,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]             remaining_q, remaining_d;
    logic [8:0]              burst_left_q, burst_left_d;
    logic [8:0]              len_q, len_d;
    logic                    start_done_q, start_done_d;
    logic                    ap_done_q, ap_done_d;

    logic [C_ADDR_WIDTH-1:0] start_addr;
    logic [32:0]             bytes_sum;
    logic [31:0]             start_beats;
    logic [12:0]             to4k_bytes;
    logic [12:0]             to4k_beats;
    logic [8:0]              burst_len;

    // rlast is never trusted: the internal beat count ends each burst.
`ifdef RD_RESP_CHK_EN
    logic err_q, err_d;
    logic unused_rlast;
    assign unused_rlast = I_m_rlast;
    assign O_err        = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{I_m_rlast, I_m_rresp};
    assign O_err       = 1'b0;
`endif

    assign start_addr  = (C_ADDR_WIDTH'(I_ddr_rd_addr) >> LG_BPB) << LG_BPB;
    assign bytes_sum   = {1'b0, I_in_data_bytes} + 33'(BPB - 1);
    assign start_beats = 32'(bytes_sum >> LG_BPB);

    // Burst length: smallest of remaining beats, max burst and beats left in the 4 KB page.
    assign to4k_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
    assign to4k_beats = to4k_bytes >> LG_BPB;

    always_comb begin
        burst_len = 9'(C_MAX_BURST);
        if (to4k_beats < 13'(C_MAX_BURST)) begin
            burst_len = to4k_beats[8:0];
        end
        if (remaining_q < 32'(burst_len)) begin
            burst_len = remaining_q[8:0];
        end
    end

    assign O_m_araddr   = addr_q;
    assign O_m_arlen    = 8'(burst_len - 9'd1);
    assign O_m_arsize   = 3'(LG_BPB);
    assign O_m_arburst  = 2'b01;
    assign O_axis_tdata = I_m_rdata;
    assign O_start_done = start_done_q;
    assign O_ap_done    = ap_done_q;
    assign O_ap_ready   = (state_q == IDLE);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        burst_left_d  = burst_left_q;
        len_d         = len_q;
        start_done_d  = 1'b0;
        ap_done_d     = 1'b0;
`ifdef RD_RESP_CHK_EN
        err_d         = err_q;
`endif
        O_m_arvalid   = 1'b0;
        O_m_rready    = 1'b0;
        O_axis_tvalid = 1'b0;
        O_axis_tlast  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (I_start) begin
                    addr_d       = start_addr;
                    remaining_d  = start_beats;
                    start_done_d = 1'b1;
`ifdef RD_RESP_CHK_EN
                    err_d        = 1'b0;
`endif
                    state_d      = (start_beats != '0) ? AR : DONE;
                end
            end
            AR: begin
                O_m_arvalid = 1'b1;
                if (I_m_arready) begin
                    burst_left_d = burst_len;
                    len_d        = burst_len;
                    state_d      = RD;
                end
            end
            RD: begin
                O_m_rready    = I_axis_tready;
                O_axis_tvalid = I_m_rvalid;
                O_axis_tlast  = I_m_rvalid && (remaining_q == 32'd1);
                if (I_m_rvalid && I_axis_tready) begin
                    remaining_d  = remaining_q - 32'd1;
                    burst_left_d = burst_left_q - 9'd1;
`ifdef RD_RESP_CHK_EN
                    if (I_m_rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
`endif
                    if (burst_left_q == 9'd1) begin
                        addr_d  = addr_q + (C_ADDR_WIDTH'(len_q) << LG_BPB);
                        state_d = (remaining_q == 32'd1) ? DONE : AR;
                    end
                end
            end
            DONE: begin
                // Registered so a zero-length transfer shows start_done and
                // ap_done on consecutive cycles.
                ap_done_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge I_aclk) begin
        if (I_arst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            burst_left_q <= '0;
            len_q        <= '0;
            start_done_q <= 1'b0;
            ap_done_q    <= 1'b0;
`ifdef RD_RESP_CHK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            burst_left_q <= burst_left_d;
            len_q        <= len_d;
            start_done_q <= start_done_d;
            ap_done_q    <= ap_done_d;
`ifdef RD_RESP_CHK_EN
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_m_axi_rd_dma.sv
`timescale 1ns/1ps
module tb_m_axi_rd_dma;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 64;
    localparam int unsigned MAXB = 16;
    localparam int unsigned BPB  = DW / 8;
`ifdef RD_RESP_CHK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk;
    logic          I_arst, I_start;
    logic [31:0]   I_ddr_rd_addr, I_in_data_bytes;
    logic          O_start_done, O_ap_done, O_ap_ready;
    logic [AW-1:0] O_m_araddr;
    logic [7:0]    O_m_arlen;
    logic [2:0]    O_m_arsize;
    logic [1:0]    O_m_arburst;
    logic          O_m_arvalid, I_m_arready;
    logic [DW-1:0] I_m_rdata;
    logic [1:0]    I_m_rresp;
    logic          I_m_rlast, I_m_rvalid, O_m_rready;
    logic [DW-1:0] O_axis_tdata;
    logic          O_axis_tvalid, O_axis_tlast, I_axis_tready;
    logic          O_err;

    m_axi_rd_dma #(
        .C_ADDR_WIDTH (AW),
        .C_DATA_WIDTH (DW),
        .C_MAX_BURST  (MAXB)
    ) dut (
        .I_aclk          (clk),
        .I_arst          (I_arst),
        .I_start         (I_start),
        .I_ddr_rd_addr   (I_ddr_rd_addr),
        .I_in_data_bytes (I_in_data_bytes),
        .O_start_done    (O_start_done),
        .O_ap_done       (O_ap_done),
        .O_ap_ready      (O_ap_ready),
        .O_m_araddr      (O_m_araddr),
        .O_m_arlen       (O_m_arlen),
        .O_m_arsize      (O_m_arsize),
        .O_m_arburst     (O_m_arburst),
        .O_m_arvalid     (O_m_arvalid),
        .I_m_arready     (I_m_arready),
        .I_m_rdata       (I_m_rdata),
        .I_m_rresp       (I_m_rresp),
        .I_m_rlast       (I_m_rlast),
        .I_m_rvalid      (I_m_rvalid),
        .O_m_rready      (O_m_rready),
        .O_axis_tdata    (O_axis_tdata),
        .O_axis_tvalid   (O_axis_tvalid),
        .O_axis_tlast    (O_axis_tlast),
        .I_axis_tready   (I_axis_tready),
        .O_err           (O_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Observations recorded by the bus model
    int unsigned   cyc = 0;
    logic [31:0]   ar_addr_q[$];
    logic [7:0]    ar_len_q[$];
    logic [2:0]    ar_size_q[$];
    logic [1:0]    ar_burst_q[$];
    logic [DW-1:0] st_data[$];
    bit            st_last[$];
    int unsigned   start_cnt, done_cnt, start_cyc, done_cyc, start_at_done;
    logic          err_at_done;
    int unsigned   ar_overlap, ar_unstable;

    // Bus model state
    logic [31:0]   pend_addr[$];
    int unsigned   pend_len[$];
    int unsigned   beat_in_burst = 0;
    bit            ar_hold = 0;
    logic [31:0]   hold_addr;
    logic [7:0]    hold_len;
    bit            r_fire;
    int unsigned   beats_sent;
    int            err_beat = -1;
    bit            rand_rdy = 0;
    bit            flip_rlast = 0;
    int unsigned   tready_mode = 0;
    bit            tr_tog = 0;

    // Expected results from the reference model
    logic [31:0]   exp_ar_addr[$];
    logic [7:0]    exp_ar_len[$];
    logic [DW-1:0] exp_data[$];

    function automatic logic [DW-1:0] mem_word(input logic [31:0] a);
        logic [DW-1:0] w;
        for (int i = 0; i < int'(DW / 32); i++) begin
            w[i*32 +: 32] = a ^ (32'(i + 1) * 32'h9E3779B9);
        end
        return w;
    endfunction

    // Transfer split computed directly from the burst rules.
    task automatic build_model(input logic [31:0] a, input logic [31:0] n);
        longint unsigned addr, beats, to4k, k;
        exp_ar_addr.delete();
        exp_ar_len.delete();
        exp_data.delete();
        addr  = longint'(a) - (longint'(a) % BPB);
        beats = (longint'(n) + BPB - 1) / BPB;
        while (beats > 0) begin
            to4k = (4096 - (addr % 4096)) / BPB;
            k = beats;
            if (k > MAXB) k = MAXB;
            if (k > to4k) k = to4k;
            exp_ar_addr.push_back(32'(addr));
            exp_ar_len.push_back(8'(k - 1));
            for (longint unsigned j = 0; j < k; j++) begin
                exp_data.push_back(mem_word(32'(addr + j * BPB)));
            end
            addr  = addr + k * BPB;
            beats = beats - k;
        end
    endtask

    // AXI slave + stream sink: observe at negedge, drive 1 ns after posedge.
    initial begin : bfm
        I_m_arready = 1'b0; I_m_rvalid = 1'b0; I_m_rdata = '0;
        I_m_rresp = 2'b00; I_m_rlast = 1'b0; I_axis_tready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            r_fire = 1'b0;
            if (I_arst) begin
                pend_addr.delete();
                pend_len.delete();
                beat_in_burst = 0;
                ar_hold = 1'b0;
            end else begin
                if (O_m_arvalid) begin
                    if (pend_len.size() != 0) ar_overlap++;
                    if (ar_hold && (O_m_araddr !== hold_addr || O_m_arlen !== hold_len)) ar_unstable++;
                    if (I_m_arready) begin
                        ar_addr_q.push_back(O_m_araddr);
                        ar_len_q.push_back(O_m_arlen);
                        ar_size_q.push_back(O_m_arsize);
                        ar_burst_q.push_back(O_m_arburst);
                        pend_addr.push_back(O_m_araddr);
                        pend_len.push_back(32'(O_m_arlen));
                        ar_hold = 1'b0;
                    end else begin
                        ar_hold   = 1'b1;
                        hold_addr = O_m_araddr;
                        hold_len  = O_m_arlen;
                    end
                end
                if (I_m_rvalid && O_m_rready) begin
                    r_fire = 1'b1;
                    beats_sent++;
                    if (pend_len.size() != 0) begin
                        if (beat_in_burst == pend_len[0]) begin
                            void'(pend_addr.pop_front());
                            void'(pend_len.pop_front());
                            beat_in_burst = 0;
                        end else begin
                            beat_in_burst++;
                        end
                    end
                end
                if (O_axis_tvalid && I_axis_tready) begin
                    st_data.push_back(O_axis_tdata);
                    st_last.push_back(O_axis_tlast);
                end
                if (O_start_done) begin
                    start_cnt++;
                    start_cyc = cyc;
                end
                if (O_ap_done) begin
                    done_cnt++;
                    done_cyc    = cyc;
                    err_at_done = O_err;
                    if (done_cnt == 1) start_at_done = start_cnt;
                end
            end
            @(posedge clk);
            #1;
            I_m_arready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
            case (tready_mode)
                0: I_axis_tready = 1'b1;
                1: I_axis_tready = ($urandom_range(0, 2) != 0);
                default: begin
                    tr_tog = ~tr_tog;
                    I_axis_tready = tr_tog;
                end
            endcase
            if (I_arst) begin
                I_m_rvalid = 1'b0;
            end else if (I_m_rvalid && !r_fire) begin
                // hold the beat until it is accepted
            end else if (pend_len.size() != 0 && (!rand_rdy || $urandom_range(0, 3) != 0)) begin
                I_m_rvalid = 1'b1;
                I_m_rdata  = mem_word(pend_addr[0] + beat_in_burst * BPB);
                I_m_rlast  = (beat_in_burst == pend_len[0]) ^ (flip_rlast && $urandom_range(0, 3) == 0);
                I_m_rresp  = (int'(beats_sent) == err_beat) ? 2'b10 : 2'b00;
            end else begin
                I_m_rvalid = 1'b0;
                I_m_rdata  = {(DW / 32){$urandom()}};
                I_m_rlast  = 1'b0;
                I_m_rresp  = 2'b00;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_records();
        ar_addr_q.delete(); ar_len_q.delete(); ar_size_q.delete(); ar_burst_q.delete();
        st_data.delete(); st_last.delete();
        start_cnt = 0; done_cnt = 0; start_at_done = 0; beats_sent = 0;
        ar_overlap = 0; ar_unstable = 0; err_at_done = 1'bx;
    endtask

    // Drives one transfer through the start handshake and waits for completion.
    task automatic do_xfer(input logic [31:0] a, input logic [31:0] n, output bit to);
        clear_records();
        I_ddr_rd_addr   = a;
        I_in_data_bytes = n;
        I_start         = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (start_cnt != 0) begin to = 1'b0; break; end
        end
        I_start = 1'b0;
        if (!to) begin
            to = 1'b1;
            for (int k = 0; k < 5000; k++) begin
                tick();
                if (done_cnt != 0) begin to = 1'b0; break; end
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        I_arst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({O_ap_ready, O_m_arvalid, O_m_rready, O_axis_tvalid, O_axis_tlast, O_start_done, O_ap_done, O_err} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 10000000",
                     {O_ap_ready, O_m_arvalid, O_m_rready, O_axis_tvalid, O_axis_tlast, O_start_done, O_ap_done, O_err});
        end
        I_arst = 1'b0;
        repeat (2) tick();
        checks++;
        if (O_ap_ready !== 1'b1 || O_m_arvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got ready=%b arvalid=%b want 1 0", O_ap_ready, O_m_arvalid);
        end
    endtask

    task automatic test_aligned();
        bit to;
        int bad;
        int nl;
        rand_rdy = 0; tready_mode = 0; flip_rlast = 0;
        build_model(32'h1000, 32'd256);
        do_xfer(32'h1000, 32'd256, to);
        checks++;
        if (to) begin errors++; $display("FAIL aligned_timeout got timeout want done"); end
        checks++;
        if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 32'h1000 || ar_len_q[0] !== 8'd15 ||
            ar_addr_q[1] !== 32'h1080 || ar_len_q[1] !== 8'd15) begin
            errors++;
            $display("FAIL aligned_ar got addr %p len %p want 1000/15 1080/15", ar_addr_q, ar_len_q);
        end
        checks++;
        bad = -1;
        foreach (ar_size_q[i]) if (bad < 0 && (ar_size_q[i] !== 3'd3 || ar_burst_q[i] !== 2'b01)) bad = i;
        if (bad != -1 || ar_size_q.size() == 0) begin
            errors++;
            $display("FAIL aligned_size_burst got %p %p want size 3 burst 1", ar_size_q, ar_burst_q);
        end
        checks++;
        bad = -1;
        if (st_data.size() != exp_data.size()) bad = -2;
        else foreach (st_data[i]) if (bad < 0 && st_data[i] !== exp_data[i]) bad = i;
        if (bad != -1) begin
            errors++;
            $display("FAIL aligned_data got %0d beats (bad idx %0d) want %0d beats", st_data.size(), bad, exp_data.size());
        end
        checks++;
        nl = 0;
        foreach (st_last[i]) if (st_last[i]) nl++;
        if (nl != 1 || st_last.size() != 32 || !st_last[31]) begin
            errors++;
            $display("FAIL aligned_tlast got %0d tlast in %0d beats want 1 on beat 32", nl, st_last.size());
        end
        checks++;
        if (done_cnt != 1 || ar_overlap != 0 || ar_unstable != 0) begin
            errors++;
            $display("FAIL aligned_proto got done=%0d overlap=%0d unstable=%0d want 1 0 0", done_cnt, ar_overlap, ar_unstable);
        end
    endtask

    task automatic test_4k();
        bit to;
        int bad;
        rand_rdy = 1; tready_mode = 0; flip_rlast = 0;
        build_model(32'h1FF0, 32'd64);
        do_xfer(32'h1FF0, 32'd64, to);
        checks++;
        if (to || ar_addr_q.size() != 2 || ar_addr_q[0] !== 32'h1FF0 || ar_len_q[0] !== 8'd1 ||
            ar_addr_q[1] !== 32'h2000 || ar_len_q[1] !== 8'd5) begin
            errors++;
            $display("FAIL cross4k_ar got addr %p len %p to=%0d want 1ff0/1 2000/5", ar_addr_q, ar_len_q, to);
        end
        checks++;
        bad = -1;
        if (st_data.size() != exp_data.size()) bad = -2;
        else foreach (st_data[i]) if (bad < 0 && (st_data[i] !== exp_data[i] || st_last[i] != (i == 7))) bad = i;
        if (bad != -1) begin
            errors++;
            $display("FAIL cross4k_data got %0d beats (bad idx %0d) want 8 beats", st_data.size(), bad);
        end
    endtask

    task automatic test_zero();
        bit to;
        rand_rdy = 0; tready_mode = 0;
        do_xfer(32'h0000_0100, 32'd0, to);
        checks++;
        if (to || ar_addr_q.size() != 0 || st_data.size() != 0) begin
            errors++;
            $display("FAIL zero_len got ars=%0d beats=%0d to=%0d want 0 0 0", ar_addr_q.size(), st_data.size(), to);
        end
        checks++;
        if (start_cnt != 1 || done_cnt != 1 || done_cyc != start_cyc + 1) begin
            errors++;
            $display("FAIL zero_timing got start=%0d@%0d done=%0d@%0d want one each, consecutive",
                     start_cnt, start_cyc, done_cnt, done_cyc);
        end
    endtask

    task automatic test_tready_toggle();
        bit to;
        rand_rdy = 0; tready_mode = 2; flip_rlast = 0;
        build_model(32'h0000_0040, 32'd13);
        do_xfer(32'h0000_0040, 32'd13, to);
        checks++;
        if (to || ar_addr_q.size() != 1 || ar_addr_q[0] !== 32'h40 || ar_len_q[0] !== 8'd1) begin
            errors++;
            $display("FAIL toggle_ar got addr %p len %p want 40/1", ar_addr_q, ar_len_q);
        end
        checks++;
        if (st_data.size() != 2 || st_data[0] !== exp_data[0] || st_data[1] !== exp_data[1] ||
            st_last[0] != 1'b0 || st_last[1] != 1'b1) begin
            errors++;
            $display("FAIL toggle_data got %0d beats last %p want 2 beats in order, tlast on 2nd", st_data.size(), st_last);
        end
        tready_mode = 0;
    endtask

    task automatic test_mid_reset();
        bit to;
        int bad;
        rand_rdy = 1; tready_mode = 1; flip_rlast = 0;
        clear_records();
        I_ddr_rd_addr = 32'h3000; I_in_data_bytes = 32'd512; I_start = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (start_cnt != 0) I_start = 1'b0;
            if (st_data.size() >= 5) begin to = 1'b0; break; end
        end
        I_start = 1'b0;
        checks++;
        if (to) begin errors++; $display("FAIL midrst_progress got %0d beats want >=5", st_data.size()); end
        I_arst = 1'b1;
        tick();
        checks++;
        if ({O_m_arvalid, O_m_rready, O_axis_tvalid, O_ap_ready} !== 4'b0001 || done_cnt != 0) begin
            errors++;
            $display("FAIL midrst_outputs got arv/rrdy/tv/ready=%b done=%0d want 0001 0",
                     {O_m_arvalid, O_m_rready, O_axis_tvalid, O_ap_ready}, done_cnt);
        end
        I_arst = 1'b0;
        tick();
        build_model(32'h5008, 32'd100);
        do_xfer(32'h5008, 32'd100, to);
        checks++;
        bad = -1;
        if (to || st_data.size() != exp_data.size() || ar_addr_q.size() != exp_ar_addr.size()) bad = -2;
        else foreach (st_data[i]) if (bad < 0 && st_data[i] !== exp_data[i]) bad = i;
        if (bad != -1) begin
            errors++;
            $display("FAIL midrst_restart got %0d beats %0d ars (bad %0d) want %0d beats %0d ars",
                     st_data.size(), ar_addr_q.size(), bad, exp_data.size(), exp_ar_addr.size());
        end
    endtask

    task automatic test_resp_err();
        bit to;
        rand_rdy = 0; tready_mode = 0;
        err_beat = 2;
        do_xfer(32'h0, 32'd64, to);
        checks++;
        if (to || err_at_done !== EXP_ERR || st_data.size() != 8) begin
            errors++;
            $display("FAIL resp_err got err=%b beats=%0d to=%0d want err=%b beats=8", err_at_done, st_data.size(), to, EXP_ERR);
        end
        err_beat = -1;
        do_xfer(32'h100, 32'd64, to);
        checks++;
        if (to || err_at_done !== 1'b0 || O_err !== 1'b0) begin
            errors++;
            $display("FAIL resp_err_clear got err=%b now=%b want 0 0", err_at_done, O_err);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        rand_rdy = 1; tready_mode = 1;
        clear_records();
        I_ddr_rd_addr = 32'h2000; I_in_data_bytes = 32'd40; I_start = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (start_cnt >= 2) begin to = 1'b0; break; end
        end
        I_start = 1'b0;
        for (int k = 0; k < 3000 && done_cnt < 2; k++) tick();
        repeat (5) tick();
        checks++;
        if (to || start_at_done != 1) begin
            errors++;
            $display("FAIL b2b_no_restart got start pulses before first done=%0d to=%0d want 1", start_at_done, to);
        end
        checks++;
        if (done_cnt != 2 || start_cnt != 2 || ar_addr_q.size() != 2 || ar_addr_q[0] !== 32'h2000 ||
            ar_addr_q[1] !== 32'h2000 || ar_len_q[0] !== 8'd4 || ar_len_q[1] !== 8'd4 || st_data.size() != 10) begin
            errors++;
            $display("FAIL b2b_pair got done=%0d start=%0d ars %p beats=%0d want 2 2 two 2000/4 10",
                     done_cnt, start_cnt, ar_addr_q, st_data.size());
        end
    endtask

    task automatic test_random();
        bit to;
        int bad, nl;
        logic [31:0] a, n;
        rand_rdy = 1; tready_mode = 1; flip_rlast = 1;
        for (int t = 0; t < 25; t++) begin
            a = ($urandom_range(0, 255) << 12) | ((t % 2 == 0) ? $urandom_range(3800, 4095) : $urandom_range(0, 4095));
            n = $urandom_range(0, 400);
            build_model(a, n);
            do_xfer(a, n, to);
            checks++;
            bad = -1;
            if (to || ar_addr_q.size() != exp_ar_addr.size()) bad = -2;
            else foreach (ar_addr_q[i]) if (bad < 0 && (ar_addr_q[i] !== exp_ar_addr[i] || ar_len_q[i] !== exp_ar_len[i])) bad = i;
            if (bad != -1) begin
                errors++;
                $display("FAIL rand_ar a=%h n=%0d got %0d ars (bad %0d) want %0d", a, n, ar_addr_q.size(), bad, exp_ar_addr.size());
            end
            checks++;
            bad = -1;
            if (st_data.size() != exp_data.size()) bad = -2;
            else foreach (st_data[i]) if (bad < 0 && st_data[i] !== exp_data[i]) bad = i;
            if (bad != -1) begin
                errors++;
                $display("FAIL rand_data a=%h n=%0d got %0d beats (bad %0d) want %0d", a, n, st_data.size(), bad, exp_data.size());
            end
            checks++;
            nl = 0;
            foreach (st_last[i]) if (st_last[i]) nl++;
            if ((exp_data.size() == 0) ? (nl != 0) : (nl != 1 || !st_last[st_last.size() - 1])) begin
                errors++;
                $display("FAIL rand_tlast a=%h n=%0d got %0d tlast in %0d beats want 1 on final", a, n, nl, st_last.size());
            end
            checks++;
            if (done_cnt != 1 || ar_overlap != 0 || ar_unstable != 0) begin
                errors++;
                $display("FAIL rand_proto a=%h n=%0d got done=%0d overlap=%0d unstable=%0d want 1 0 0",
                         a, n, done_cnt, ar_overlap, ar_unstable);
            end
        end
        flip_rlast = 0;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog got no finish want finish within time limit");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        I_arst = 1'b1; I_start = 1'b0; I_ddr_rd_addr = '0; I_in_data_bytes = '0;
        test_reset();
        test_aligned();
        test_4k();
        test_zero();
        test_tready_toggle();
        test_mid_reset();
        test_resp_err();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
